pattern_detect: RTL and testbench
=================================

# pattern_detect

Parametrised serial pattern detector, successor to the fixed 0x58 detector. It shifts in one bit per valid cycle and compares the last WIDTH bits against a runtime-loadable pattern. Overlapping and non-overlapping detection are both supported, and a saturating match counter is kept. It sits on the serial input path as a standalone block and drives a single-cycle match pulse to downstream control.

## Interface
- WIDTH, 8: pattern length in bits, legal range 2..16.
- CNT_W, 8: match counter width, legal range 1..16.
- DEFAULT_PAT, 8'h58: pattern value after reset, WIDTH bits.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- load  in  1  latch `pat_in` as the new pattern; also flushes history.
- pat_in  in  WIDTH  new pattern, sampled only when `load`=1.
- overlap  in  1  1 = overlapping detection, 0 = non-overlapping; sampled every cycle.
- in_valid  in  1  `in` carries a bit this cycle.
- in  in  1  serial data bit.
- match  out  1  one-cycle pulse on pattern match.
- count  out  CNT_W  number of matches, saturating.
- armed  out  1  history holds at least WIDTH valid bits.

## Operation
- Registers:
  - `pat` (WIDTH)
  - `hist` (WIDTH shift register)
  - `fill` (0..WIDTH fill counter)
  - `count`
  - `match`
- Bit order:
  - The newest bit enters `hist[0]` and older bits shift toward the MSB.
  - The first-received bit of a sequence is therefore compared against `pat[WIDTH-1]`.
  - Example: 0x58 matches the stream 0,1,0,1,1,0,0,0.
- States, encoded by `fill`:
  - EMPTY: `fill`=0.
  - FILLING: 0<`fill`<WIDTH.
  - ARMED: `fill`=WIDTH. `armed` = (`fill`==WIDTH).
- Per cycle, evaluated in priority order:
  1. `rst`: `pat`=DEFAULT_PAT, `hist`=0, `fill`=0, `count`=0, `match`=0.
  2. `load`: `pat`=`pat_in`, `hist`=0, `fill`=0, `match`=0. `count` is held. A coincident `in_valid` bit is discarded.
  3. `in_valid`:
     - `hist_n` = {`hist`[WIDTH-2:0], `in`}.
     - `fill_n` = min(`fill`+1, WIDTH).
     - `hit` = (`fill_n`==WIDTH) && (`hist_n`==`pat`).
     - `match` = `hit`.
     - On `hit`, `count` increments unless it equals 2^CNT_W-1, where it holds.
     - On `hit` with `overlap`=0, `fill` is forced to 0 instead of `fill_n`, so the next match needs WIDTH fresh bits. `hist` still takes `hist_n`.
     - Otherwise `fill` = `fill_n`.
  4. Idle (no `in_valid`): `hist`, `fill`, `count` are held and `match`=0.
- Changing `overlap` mid-stream takes effect on the next valid bit and does not flush history.
- Neither `load` nor `overlap` clears `count`; only `rst` does.

## Timing
- Latency: `match` is registered and asserts in the cycle after the edge that samples the completing bit. It is high for exactly one cycle.
- Back-to-back matches are possible:
  - Overlapping mode: two valid bits apart, for periodic patterns such as 10101010.
  - Non-overlapping mode: at minimum WIDTH valid bits apart.
- Gaps in `in_valid` do not break a sequence; history is bit-indexed, not cycle-indexed.
- Reset values: `match`=0, `count`=0, `armed`=0.
- Reset mid-stream discards all history.
- After `load`, the earliest possible match is WIDTH valid bits later.
- `count` and `armed` are registered outputs with no combinational path from inputs.

## Structure
- Shared package / header `detect_pkg` holds:
  - default WIDTH and CNT_W
  - DEFAULT_PAT
  - fill-state constants: FILL_EMPTY=0, FILL_FULL=WIDTH
- One sub-module, `pattern_shift_reg`, parametrised by WIDTH. It covers the shift register with shift-enable and synchronous clear, built from the codebase's existing dff cells.
- Comparator, fill counter, match counter and output register stay in `pattern_detect`.

## Test plan
- Reset then default pattern: `rst` 1 cycle, stream 0,1,0,1,1,0,0,0 with `in_valid`=1 → `match` pulses once, the cycle after bit 8. `count`=1, `armed`=1 from bit 8.
- Overlap: `load` `pat_in`=8'hAA, `overlap`=1, stream 1,0 repeated ×6 → `match` after bits 8, 10 and 12. `count`=3.
- Non-overlap: same stream with `overlap`=0 → `match` only after bit 8. `count`=1. `armed`=0 after the match.
- Gaps plus reset mid-stream:
  - Stream 0101 with `in_valid` gaps of 3 idle cycles, then 1000 → one match.
  - Repeat with `rst` asserted after the 5th bit → no match. The next full 8-bit sequence matches.
- Saturation: CNT_W=2, overlap pattern 8'h00, 12 zeros → 5 matches occur; `count` sequence 1,2,3,3,3.
- Load collision: `load` coincident with the 8th bit of a matching sequence → no `match`, new `pat` active. `count` is unchanged and `fill`=0.

Source files
------------

// File: rtl/detect_pkg.sv
// Shared constants and fill-state helpers for the serial pattern detector.
package detect_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNT_W = 8;
    localparam logic [15:0] DEFAULT_PAT = 16'h0058;

    // Fill-state boundaries; FILL_FULL tracks the default width, the top scales it to its own WIDTH.
    localparam int FILL_EMPTY = 0;
    localparam int FILL_FULL  = DEF_WIDTH;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_FILLING,
        ST_ARMED
    } fill_state_e;

    function automatic fill_state_e fill_state(input int fill, input int width);
        if (fill == FILL_EMPTY)
            return ST_EMPTY;
        else if (fill >= width)
            return ST_ARMED;
        else
            return ST_FILLING;
    endfunction

endpackage

// File: rtl/pattern_shift_reg.sv
// History shift register: newest bit enters bit 0, older bits move toward the MSB.
module pattern_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             shift_en,
    input  logic             d,
    output logic [WIDTH-1:0] q
);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || clr)
            q <= '0;
        else if (shift_en)
            q <= {q[WIDTH-2:0], d};
    end

endmodule

// File: rtl/pattern_detect.sv
// Parametrised serial pattern detector with runtime-loadable pattern,
// overlapping/non-overlapping modes and a saturating match counter.
module pattern_detect #(
    parameter int               WIDTH       = detect_pkg::DEF_WIDTH,
    parameter int               CNT_W       = detect_pkg::DEF_CNT_W,
    parameter logic [WIDTH-1:0] DEFAULT_PAT = WIDTH'(detect_pkg::DEFAULT_PAT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] pat_in,
    input  logic             overlap,
    input  logic             in_valid,
    input  logic             in,
    output logic             match,
    output logic [CNT_W-1:0] count,
    output logic             armed
);

    import detect_pkg::*;

    localparam int               FW       = $clog2(WIDTH + 1);
    localparam logic [FW-1:0]    FILL_MAX = FW'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [WIDTH-1:0] pat;
    logic [WIDTH-1:0] hist;
    logic [WIDTH-1:0] hist_n;
    logic [FW-1:0]    fill;
    logic [FW-1:0]    fill_n;
    logic             hit;
    fill_state_e      state;

    pattern_shift_reg #(.WIDTH(WIDTH)) u_hist (
        .clk      (clk),
        .rst      (rst),
        .clr      (load),
        .shift_en (in_valid),
        .d        (in),
        .q        (hist)
    );

    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        hist_n = {hist[WIDTH-2:0], in};
        fill_n = fill;
        if (fill != FILL_MAX)
            fill_n = fill + 1'b1;
        hit    = (fill_n == FILL_MAX) && (hist_n == pat);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pat   <= DEFAULT_PAT;
            fill  <= FW'(FILL_EMPTY);
            count <= '0;
            match <= 1'b0;
        end else if (load) begin
            pat   <= pat_in;
            fill  <= FW'(FILL_EMPTY);
            match <= 1'b0;
        end else if (in_valid) begin
            match <= hit;
            if (hit && count != CNT_MAX)
                count <= count + 1'b1;
            // Non-overlapping mode restarts the fill so the next match needs WIDTH fresh bits.
            if (hit && !overlap)
                fill <= FW'(FILL_EMPTY);
            else
                fill <= fill_n;
        end else begin
            match <= 1'b0;
        end
    end

    assign state = fill_state(int'(fill), WIDTH);
    assign armed = (state == ST_ARMED);

endmodule

// File: tb/tb_pattern_detect.sv
// Self-checking bench: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_pattern_detect;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] pat_in = '0;
    logic         overlap = 1'b1;
    logic         in_valid = 1'b0;
    logic         din = 1'b0;

    logic         match_a, armed_a;
    logic [7:0]   count_a;
    logic         match_b, armed_b;
    logic [1:0]   count_b;

    int n_cmp = 0;
    int n_err = 0;
    int pulses = 0;

    // Reference model state
    logic [W-1:0] m_pat = 8'h58;
    bit           bits[$];
    int           m_cnt8 = 0;
    int           m_cnt2 = 0;
    bit           m_match = 0;

    always #5 clk = ~clk;

    pattern_detect #(.WIDTH(W), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .load(load), .pat_in(pat_in), .overlap(overlap),
        .in_valid(in_valid), .in(din), .match(match_a), .count(count_a), .armed(armed_a)
    );

    pattern_detect #(.WIDTH(W), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .load(load), .pat_in(pat_in), .overlap(overlap),
        .in_valid(in_valid), .in(din), .match(match_b), .count(count_b), .armed(armed_b)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // The last W received bits, oldest first, must equal the pattern MSB first.
    function automatic bit window_matches();
        for (int i = 0; i < W; i++)
            if (bits[i] != m_pat[W-1-i]) return 0;
        return 1;
    endfunction

    function automatic void model_step(input bit r, input bit l, input logic [W-1:0] p,
                                       input bit ov, input bit v, input bit b);
        bit h;
        if (r) begin
            m_pat = 8'h58; bits.delete(); m_cnt8 = 0; m_cnt2 = 0; m_match = 0;
        end else if (l) begin
            m_pat = p; bits.delete(); m_match = 0;
        end else if (v) begin
            bits.push_back(b);
            if (bits.size() > W) void'(bits.pop_front());
            h = (bits.size() == W) && window_matches();
            m_match = h;
            if (h) begin
                if (m_cnt8 < 255) m_cnt8++;
                if (m_cnt2 < 3) m_cnt2++;
                if (!ov) bits.delete();
            end
        end else begin
            m_match = 0;
        end
    endfunction

    task automatic step(input bit r, input bit l, input logic [W-1:0] p,
                        input bit ov, input bit v, input bit b);
        rst = r; load = l; pat_in = p; overlap = ov; in_valid = v; din = b;
        @(posedge clk);
        model_step(r, l, p, ov, v, b);
        #1;
        if (match_a) pulses++;
        check("match", int'(match_a), int'(m_match));
        check("count", int'(count_a), m_cnt8);
        check("armed", int'(armed_a), int'(bits.size() == W));
        check("sat_match", int'(match_b), int'(m_match));
        check("sat_count", int'(count_b), m_cnt2);
        check("sat_armed", int'(armed_b), int'(bits.size() == W));
    endtask

    task automatic send_bit(input bit ov, input bit b);
        step(0, 0, '0, ov, 1, b);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, '0, overlap, 0, 0);
    endtask

    task automatic do_reset();
        step(1, 0, '0, 1, 0, 0);
        pulses = 0;
    endtask

    task automatic do_load(input logic [W-1:0] p, input bit ov);
        step(0, 1, p, ov, 0, 0);
        pulses = 0;
    endtask

    initial begin
        logic [W-1:0] seq;
        logic [W-1:0] rp;
        int           mode;

        // Reset state
        step(1, 0, '0, 1, 0, 0);
        check("rst_match", int'(match_a), 0);
        check("rst_count", int'(count_a), 0);
        check("rst_armed", int'(armed_a), 0);
        pulses = 0;

        // Default pattern 0x58, first bit compared against the MSB
        seq = 8'h58;
        for (int i = W - 1; i >= 0; i--) begin
            send_bit(1, seq[i]);
            if (i == 1) check("dflt_no_early", pulses, 0);
        end
        check("dflt_match_bit8", int'(match_a), 1);
        check("dflt_armed_bit8", int'(armed_a), 1);
        idle(1);
        check("dflt_pulse_once", pulses, 1);
        check("dflt_count", int'(count_a), 1);

        // Overlap with periodic pattern
        do_reset();
        do_load(8'hAA, 1);
        for (int i = 0; i < 12; i++) send_bit(1, (i % 2 == 0));
        check("ovl_pulses", pulses, 3);
        check("ovl_count", int'(count_a), 3);

        // Non-overlap, same stream
        do_reset();
        do_load(8'hAA, 0);
        for (int i = 0; i < 12; i++) send_bit(0, (i % 2 == 0));
        check("novl_pulses", pulses, 1);
        check("novl_count", int'(count_a), 1);
        check("novl_armed", int'(armed_a), 0);

        // Gaps in in_valid do not break a sequence
        do_reset();
        for (int i = W - 1; i >= 0; i--) begin
            send_bit(1, seq[i]);
            if (i >= 4) idle(3);
        end
        idle(1);
        check("gap_pulses", pulses, 1);

        // Reset after the 5th bit discards history
        do_reset();
        for (int i = W - 1; i >= 3; i--) begin
            send_bit(1, seq[i]);
            if (i >= 4) idle(3);
        end
        do_reset();
        for (int i = 2; i >= 0; i--) send_bit(1, seq[i]);
        check("rstmid_pulses", pulses, 0);
        for (int i = W - 1; i >= 0; i--) send_bit(1, seq[i]);
        check("rstmid_rematch", pulses, 1);

        // Saturation: 12 zeros against 0x00 gives five matches
        do_reset();
        do_load(8'h00, 1);
        for (int i = 0; i < 12; i++) send_bit(1, 0);
        check("sat_pulses", pulses, 5);
        check("sat_cnt2", int'(count_b), 3);
        check("sat_cnt8", int'(count_a), 5);

        // Load collides with the completing bit
        do_reset();
        for (int i = W - 1; i >= 1; i--) send_bit(1, seq[i]);
        step(0, 1, 8'hF0, 1, 1, seq[0]);
        check("coll_match", int'(match_a), 0);
        check("coll_count", int'(count_a), 0);
        check("coll_armed", int'(armed_a), 0);
        for (int i = 0; i < W; i++) send_bit(1, (i < 4));
        check("coll_newpat", pulses, 1);

        // Randomized traffic in phases biased toward producing matches
        do_reset();
        for (int ph = 0; ph < 8; ph++) begin
            mode = ph % 4;
            case (mode)
                0:       rp = 8'hFF;
                1:       rp = 8'h00;
                2:       rp = 8'hAA;
                default: rp = W'($urandom);
            endcase
            step(0, 1, rp, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
            for (int c = 0; c < 400; c++) begin
                bit r, l, ov, v, b;
                r  = ($urandom_range(0, 199) == 0);
                l  = ($urandom_range(0, 149) == 0);
                ov = ($urandom_range(0, 9) < 6);
                v  = ($urandom_range(0, 9) < 7);
                case (mode)
                    0:       b = ($urandom_range(0, 19) != 0);
                    1:       b = ($urandom_range(0, 19) == 0);
                    2:       b = ((c % 2) == 0) ^ ($urandom_range(0, 29) == 0);
                    default: b = $urandom_range(0, 1);
                endcase
                step(r, l, rp, ov, v, b);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
